mem_resp: RTL and testbench

- System-bus memory module: the responder end of the CPU's memory read/write handshake.
- Decodes rr_/rw_ cycles addressed to its segment number and serves them from an internal word array with a stored parity bit.
- Answers with dok_ (and ddt_ data on read), or with dpe_ on a read parity mismatch.
- Does not answer cycles that are not its own, so the CPU's no-answer alarm path can be exercised.

---
 rtl/mem_resp_if.sv | 22 ++
 rtl/mem_resp.sv | 217 +++++++++++++++++++++
 tb/tb_mem_resp.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_resp_if.sv
// Memory read/write handshake between the CPU (master) and a memory
// responder (slave). Every line is active low, as it is on the system bus.
interface mem_resp_if;
  logic        rr_;
  logic        rw_;
  logic [0:3]  rnb_;
  logic [0:15] rad_;
  logic [0:15] rdt_;
  logic        dok_;
  logic        dpe_;
  logic [0:15] ddt_;

  modport master (
    output rr_, rw_, rnb_, rad_, rdt_,
    input  dok_, dpe_, ddt_
  );

  modport slave (
    input  rr_, rw_, rnb_, rad_, rdt_,
    output dok_, dpe_, ddt_
  );
endinterface

// File: rtl/mem_resp.sv
// Responder end of the CPU memory handshake. Decodes read/write cycles aimed
// at segment NB, serves them from a word array with one stored parity bit per
// word, and answers with dok_ (plus ddt_ on reads) or dpe_ on a read parity
// mismatch. Cycles for other segments or beyond the array stay unanswered.
module mem_resp #(
  parameter logic [3:0] NB            = 4'd0,
  parameter int         ADDR_BITS     = 12,
  parameter logic [3:0] ACCESS_TICKS  = 4'd10,
  parameter logic [7:0] RELEASE_TICKS = 8'd200
) (
  input  logic          __clk,
  input  logic          clm_,
  mem_resp_if.slave     bus,
  input  logic          pe_inj,
  output logic          busy
);

  localparam int WORDS = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MISS   = 2'd1,
    ACCESS = 2'd2,
    ANSWER = 2'd3
  } state_t;

  function automatic logic parity16(input logic [15:0] d);
    return ^d;
  endfunction

  // Bus inputs packed as {rr_, rw_, rnb_[0:3], rad_[0:15], rdt_[0:15]}.
  logic [37:0] sync1_r;
  logic [37:0] sync2_r;

  logic        rr_s;
  logic        rw_s;
  logic [3:0]  rnb_s;
  logic [15:0] addr_s;
  logic [15:0] wdata_s;
  logic        hit_s;
  logic        req_s;

  state_t                 state_r;
  state_t                 state_n;
  logic [7:0]             cnt_r;
  logic [7:0]             cnt_n;
  logic                   is_wr_r;
  logic [ADDR_BITS-1:0]   addr_r;
  logic [15:0]            wdata_r;
  logic                   dok_r;
  logic                   dok_n;
  logic                   dpe_r;
  logic                   dpe_n;
  logic [15:0]            ddt_r;
  logic [15:0]            ddt_n;
  logic                   busy_r;
  logic                   latch_s;
  logic                   mem_we_s;

  logic [15:0]            mem_r [0:WORDS-1];
  logic                   par_r [0:WORDS-1];
  logic [15:0]            mem_rd_s;
  logic                   pe_s;

  // Two-flop synchronizer for every bus input; idles at all ones.
  always_ff @(posedge __clk or negedge clm_) begin
    if (!clm_) begin
      sync1_r <= {38{1'b1}};
      sync2_r <= {38{1'b1}};
    end else begin
      sync1_r <= {bus.rr_, bus.rw_, bus.rnb_, bus.rad_, bus.rdt_};
      sync2_r <= sync1_r;
    end
  end

  assign rr_s    = sync2_r[37];
  assign rw_s    = sync2_r[36];
  assign rnb_s   = sync2_r[35:32];
  assign addr_s  = ~sync2_r[31:16];
  assign wdata_s = ~sync2_r[15:0];

  // Hit needs our segment and no address bits above the implemented range.
  assign hit_s = (~rnb_s == NB) && ((addr_s >> ADDR_BITS) == 16'd0);

  // The request line that started the current cycle is still held low.
  assign req_s = is_wr_r ? ~rw_s : ~rr_s;

  assign mem_rd_s = mem_r[addr_r];
  assign pe_s     = (parity16(mem_rd_s) != par_r[addr_r]);

  // Next-state, counter and answer decode.
  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    dok_n    = dok_r;
    dpe_n    = dpe_r;
    ddt_n    = ddt_r;
    latch_s  = 1'b0;
    mem_we_s = 1'b0;
    case (state_r)
      IDLE: begin
        // Exactly one request low; both low is a protocol error and ignored.
        if (rr_s ^ rw_s) begin
          latch_s = 1'b1;
          cnt_n   = 8'd0;
          state_n = hit_s ? ACCESS : MISS;
        end else begin
          state_n = IDLE;
        end
      end
      MISS: begin
        if (rr_s && rw_s) begin
          state_n = IDLE;
        end else begin
          state_n = MISS;
        end
      end
      ACCESS: begin
        if (!req_s) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
        end else begin
          if ((cnt_r == 8'd0) && is_wr_r) begin
            mem_we_s = 1'b1;
          end else begin
            mem_we_s = 1'b0;
          end
          if (cnt_r == ({4'd0, ACCESS_TICKS} - 8'd1)) begin
            state_n = ANSWER;
            cnt_n   = 8'd0;
            if (is_wr_r) begin
              dok_n = 1'b0;
            end else if (pe_s) begin
              dpe_n = 1'b0;
            end else begin
              dok_n = 1'b0;
              ddt_n = ~mem_rd_s;
            end
          end else begin
            cnt_n = cnt_r + 8'd1;
          end
        end
      end
      ANSWER: begin
        if (!req_s) begin
          state_n = IDLE;
          cnt_n   = 8'd0;
          dok_n   = 1'b1;
          dpe_n   = 1'b1;
          ddt_n   = 16'hffff;
        end else if (cnt_r == (RELEASE_TICKS - 8'd1)) begin
          // Requester never let go: drop the answer and wait out the release.
          state_n = MISS;
          cnt_n   = 8'd0;
          dok_n   = 1'b1;
          dpe_n   = 1'b1;
          ddt_n   = 16'hffff;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
        dok_n   = 1'b1;
        dpe_n   = 1'b1;
        ddt_n   = 16'hffff;
      end
    endcase
  end

  // State, counter and registered bus answer.
  always_ff @(posedge __clk or negedge clm_) begin
    if (!clm_) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      dok_r   <= 1'b1;
      dpe_r   <= 1'b1;
      ddt_r   <= 16'hffff;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      dok_r   <= dok_n;
      dpe_r   <= dpe_n;
      ddt_r   <= ddt_n;
      busy_r  <= (state_n != IDLE);
    end
  end

  // Capture operation, address and write data when a cycle is accepted.
  always_ff @(posedge __clk or negedge clm_) begin
    if (!clm_) begin
      is_wr_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 16'd0;
    end else if (latch_s) begin
      is_wr_r <= ~rw_s;
      addr_r  <= addr_s[ADDR_BITS-1:0];
      wdata_r <= wdata_s;
    end
  end

  // Word array and parity store; contents survive reset.
  always_ff @(posedge __clk) begin
    if (mem_we_s) begin
      mem_r[addr_r] <= wdata_r;
      par_r[addr_r] <= parity16(wdata_r) ^ pe_inj;
    end
  end

  assign bus.dok_ = dok_r;
  assign bus.dpe_ = dpe_r;
  assign bus.ddt_ = ddt_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: table of bus transactions with expected answers, plus
// hand-written sequences for reset abort, release timeout and double request.
module tb_mem_resp;

  localparam int AT  = 10;
  localparam int RT  = 200;
  localparam int LAT = 3 + AT;

  logic clk;
  logic clm_;
  logic pe_inj;
  logic busy;

  mem_resp_if bus ();

  mem_resp #(
    .NB            (4'd0),
    .ADDR_BITS     (12),
    .ACCESS_TICKS  (4'd10),
    .RELEASE_TICKS (8'd200)
  ) dut (
    .__clk  (clk),
    .clm_   (clm_),
    .bus    (bus),
    .pe_inj (pe_inj),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = no answer, 1 = dok_, 2 = dpe_
  typedef struct packed {
    logic        wr;
    logic [3:0]  nb;
    logic [15:0] addr;
    logic [15:0] data;
    logic        inj;
    logic [1:0]  kind;
    logic [15:0] ddt;
  } vec_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] ddt;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[15];
  int total = 0;
  int bad   = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ans_kind();
    if (bus.dok_ === 1'b0) return 2'd1;
    else if (bus.dpe_ === 1'b0) return 2'd2;
    else return 2'd0;
  endfunction

  task automatic idle_bus();
    bus.rr_  = 1'b1;
    bus.rw_  = 1'b1;
    bus.rnb_ = 4'hf;
    bus.rad_ = 16'hffff;
    bus.rdt_ = 16'hffff;
  endtask

  task automatic drive(input logic wr, input logic [3:0] nb, input logic [15:0] addr,
                       input logic [15:0] data, input logic inj);
    bus.rnb_ = ~nb;
    bus.rad_ = ~addr;
    bus.rdt_ = ~data;
    pe_inj   = inj;
    if (wr) bus.rw_ = 1'b0;
    else    bus.rr_ = 1'b0;
  endtask

  // Release the request and check the answer and busy are gone.
  task automatic release_chk(input string nm);
    @(negedge clk);
    idle_bus();
    pe_inj = 1'b0;
    repeat (3) tick();
    chk1({nm, " rel dok_"}, bus.dok_, 1'b1);
    chk1({nm, " rel dpe_"}, bus.dpe_, 1'b1);
    chk16({nm, " rel ddt_"}, bus.ddt_, 16'hffff);
    chk1({nm, " rel busy"}, busy, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    exp_t e;
    int   win;
    logic early;
    logic seen;
    @(negedge clk);
    drive(v.wr, v.nb, v.addr, v.data, v.inj);
    sb_q.push_back('{kind: v.kind, ddt: v.ddt});
    win   = (v.kind == 2'd0) ? 500 : LAT;
    early = 1'b0;
    seen  = 1'b0;
    for (int k = 1; k <= win; k++) begin
      tick();
      if (ans_kind() != 2'd0) begin
        seen = 1'b1;
        if (k < win) early = 1'b1;
      end
    end
    e = sb_q.pop_front();
    if (e.kind == 2'd0) begin
      chk1({nm, " no answer"}, seen, 1'b0);
    end else begin
      chk1({nm, " early answer"}, early, 1'b0);
      chk16({nm, " answer kind"}, {14'd0, ans_kind()}, {14'd0, e.kind});
      chk16({nm, " ddt_"}, bus.ddt_, e.ddt);
    end
    chk1({nm, " busy"}, busy, 1'b1);
    release_chk(nm);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    exp_t e;
    logic seen;
    logic busy_seen;

    //           wr    nb    addr      data      inj   kind  ddt
    vecs[0]  = '{1'b1, 4'd0, 16'h0005, 16'h1234, 1'b0, 2'd1, 16'hffff};
    vecs[1]  = '{1'b0, 4'd0, 16'h0005, 16'h0000, 1'b0, 2'd1, 16'hedcb};
    vecs[2]  = '{1'b1, 4'd3, 16'h0005, 16'h5555, 1'b0, 2'd0, 16'hffff};
    vecs[3]  = '{1'b0, 4'd0, 16'h0005, 16'h0000, 1'b0, 2'd1, 16'hedcb};
    vecs[4]  = '{1'b1, 4'd0, 16'h0fff, 16'hbeef, 1'b0, 2'd1, 16'hffff};
    vecs[5]  = '{1'b1, 4'd0, 16'h1000, 16'h1111, 1'b0, 2'd0, 16'hffff};
    vecs[6]  = '{1'b0, 4'd0, 16'h0fff, 16'h0000, 1'b0, 2'd1, 16'h4110};
    vecs[7]  = '{1'b0, 4'd0, 16'h1000, 16'h0000, 1'b0, 2'd0, 16'hffff};
    vecs[8]  = '{1'b1, 4'd0, 16'h0000, 16'h0f0f, 1'b0, 2'd1, 16'hffff};
    vecs[9]  = '{1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 2'd1, 16'hf0f0};
    vecs[10] = '{1'b1, 4'd0, 16'h0003, 16'h00ff, 1'b1, 2'd1, 16'hffff};
    vecs[11] = '{1'b0, 4'd0, 16'h0003, 16'h0000, 1'b0, 2'd2, 16'hffff};
    vecs[12] = '{1'b1, 4'd0, 16'h0003, 16'h00ff, 1'b0, 2'd1, 16'hffff};
    vecs[13] = '{1'b0, 4'd0, 16'h0003, 16'h0000, 1'b0, 2'd1, 16'hff00};
    vecs[14] = '{1'b1, 4'd0, 16'h0008, 16'h1357, 1'b0, 2'd1, 16'hffff};

    // Reset state
    clm_   = 1'b0;
    pe_inj = 1'b0;
    idle_bus();
    repeat (3) tick();
    chk1("reset dok_", bus.dok_, 1'b1);
    chk1("reset dpe_", bus.dpe_, 1'b1);
    chk16("reset ddt_", bus.ddt_, 16'hffff);
    chk1("reset busy", busy, 1'b0);
    @(negedge clk);
    clm_ = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during ACCESS of a write, before its first access tick
    @(negedge clk);
    clm_ = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    clm_ = 1'b1;
    run_vec('{1'b1, 4'd0, 16'h0007, 16'haaaa, 1'b0, 2'd1, 16'hffff}, "wr7");
    @(negedge clk);
    drive(1'b1, 4'd0, 16'h0008, 16'h5555, 1'b0);
    repeat (3) tick();
    chk1("abort busy before reset", busy, 1'b1);
    @(negedge clk);
    clm_ = 1'b0;
    idle_bus();
    #1;
    chk1("abort dok_", bus.dok_, 1'b1);
    chk1("abort dpe_", bus.dpe_, 1'b1);
    chk16("abort ddt_", bus.ddt_, 16'hffff);
    chk1("abort busy", busy, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    clm_ = 1'b1;
    run_vec('{1'b0, 4'd0, 16'h0007, 16'h0000, 1'b0, 2'd1, 16'h5555}, "rd7");
    run_vec('{1'b0, 4'd0, 16'h0008, 16'h0000, 1'b0, 2'd1, 16'heca8}, "rd8");

    // Hold rr_ low past the release timeout
    @(negedge clk);
    drive(1'b0, 4'd0, 16'h0005, 16'h0000, 1'b0);
    sb_q.push_back('{kind: 2'd1, ddt: 16'hedcb});
    repeat (LAT) tick();
    e = sb_q.pop_front();
    chk16("hold answer kind", {14'd0, ans_kind()}, {14'd0, e.kind});
    chk16("hold ddt_", bus.ddt_, e.ddt);
    repeat (RT - 1) tick();
    chk1("hold dok_ before timeout", bus.dok_, 1'b0);
    tick();
    chk1("timeout dok_", bus.dok_, 1'b1);
    chk16("timeout ddt_", bus.ddt_, 16'hffff);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (ans_kind() != 2'd0) seen = 1'b1;
    end
    chk1("timeout no reanswer", seen, 1'b0);
    chk1("timeout busy", busy, 1'b1);
    release_chk("timeout");
    run_vec('{1'b0, 4'd0, 16'h0005, 16'h0000, 1'b0, 2'd1, 16'hedcb}, "after timeout");

    // rr_ and rw_ low together: no answer, no write
    @(negedge clk);
    bus.rnb_ = 4'hf;
    bus.rad_ = ~16'h0005;
    bus.rdt_ = ~16'h9999;
    bus.rr_  = 1'b0;
    bus.rw_  = 1'b0;
    seen      = 1'b0;
    busy_seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (ans_kind() != 2'd0) seen = 1'b1;
      if (busy) busy_seen = 1'b1;
    end
    chk1("both low no answer", seen, 1'b0);
    chk1("both low busy", busy_seen, 1'b0);
    release_chk("both low");
    run_vec('{1'b0, 4'd0, 16'h0005, 16'h0000, 1'b0, 2'd1, 16'hedcb}, "after both low");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
